// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences mult/div over a fixed latency, serves mf/mt ops.
// Optional madd/maddu/msub/msubu support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;

  logic        is_mul, is_div, is_acc, is_md;
  logic [63:0] hilo, prod_s, prod_u, md_res;
  logic [31:0] q_s, r_s, q_u, r_u;

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_acc = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
    is_acc = 1'b0;
`endif
    is_md = is_mul || is_div || is_acc;
  end

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  always_comb begin
    hilo   = {hi_q, lo_q};
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    q_s    = $signed(rs_val) / $signed(rt_val);
    r_s    = $signed(rs_val) % $signed(rt_val);
    q_u    = rs_val / rt_val;
    r_u    = rs_val % rt_val;
  end

  // Divide by zero keeps the current HI/LO as the commit value.
  always_comb begin
    md_res = hilo;
    case (op)
      OP_MULT:  md_res = prod_s;
      OP_MULTU: md_res = prod_u;
      OP_DIV:   if (rt_val != 32'd0) md_res = {r_s, q_s};
      OP_DIVU:  if (rt_val != 32'd0) md_res = {r_u, q_u};
      OP_MADD:  md_res = hilo + prod_s;
      OP_MADDU: md_res = hilo + prod_u;
      OP_MSUB:  md_res = hilo - prod_s;
      OP_MSUBU: md_res = hilo - prod_u;
      default:  md_res = hilo;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_md) begin
            state_d = BUSY;
            cnt_d   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            sh_hi_d = md_res[63:32];
            sh_lo_d = md_res[31:0];
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
    end
  end

  always_comb begin
    busy      = (state_q == BUSY);
    stall_req = d_is_md && (busy || (start && is_md));
    hi        = hi_q;
    lo        = lo_q;
    if (op == OP_MFHI)      rdata = hi_q;
    else if (op == OP_MFLO) rdata = lo_q;
    else                    rdata = 32'd0;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level HI/LO model.
module tb_mdu_ctrl;
  localparam int MLAT = 5;
  localparam int DLAT = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk, reset, start, d_is_md;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall_req;
  logic [31:0] hi, lo, rdata;

  int checks = 0;
  int errors = 0;

  // Model state: architectural HI/LO, pending result and remaining busy cycles.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  bit          m_valid = 1'b0;

  mdu_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .d_is_md(d_is_md), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit md_op(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (MADD && o >= 4'd9 && o <= 4'd12);
  endfunction

  function automatic logic [63:0] model_res(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint sa, sb;
    longint unsigned ua, ub, base;
    int ia, ib, q, r;
    sa = int'(a); sb = int'(b); ua = 64'(a); ub = 64'(b);
    base = {h, l};
    ia = a; ib = b;
    case (o)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 0) return {h, l};
        q = ia / ib; r = ia % ib;
        return {r, q};
      end
      4'd4: begin
        if (b == 0) return {h, l};
        return {a % b, a / b};
      end
      4'd9:  return base + 64'(sa * sb);
      4'd10: return base + ua * ub;
      4'd11: return base - 64'(sa * sb);
      4'd12: return base - ua * ub;
      default: return {h, l};
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (start) begin
      if (md_op(op)) begin
        {m_phi, m_plo} = model_res(op, rs_val, rt_val, m_hi, m_lo);
        m_left = (op == 4'd3 || op == 4'd4) ? DLAT : MLAT;
      end else if (op == 4'd7) m_hi = rs_val;
      else if (op == 4'd8) m_lo = rs_val;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_rd;
    logic        exp_busy, exp_stall;
    if (!m_valid) return;
    exp_busy  = (m_left > 0);
    exp_stall = d_is_md && (exp_busy || (start && md_op(op)));
    exp_rd    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    cmp("busy", 32'(busy), 32'(exp_busy));
    cmp("stall_req", 32'(stall_req), 32'(exp_stall));
    cmp("hi", hi, m_hi);
    cmp("lo", lo, m_lo);
    cmp("rdata", rdata, exp_rd);
  endtask

  // Inputs are set at a falling edge; check, clock the model, return at the next falling edge.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    idle_inputs();
  endtask

  // Counts busy cycles (bounded) and checks stall_req each busy cycle and on the falling cycle.
  task automatic run_busy(input string name, input int exp_n, input logic exp_stall);
    int n = 0;
    while (busy && n < 40) begin
      #1 cmp({name, "_stall"}, 32'(stall_req), 32'(exp_stall));
      tick();
      n++;
    end
    cmp({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
    #1 cmp({name, "_stall_after"}, 32'(stall_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; d_is_md = 1'b0;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_hi", hi, 32'd0);
    cmp("reset_lo", lo, 32'd0);
    cmp("reset_rdata", rdata, 32'd0);

    // mult / multu, stall with d_is_md high
    d_is_md = 1'b1;
    start = 1'b1; op = 4'd1; rs_val = 32'hFFFFFFFF; rt_val = 32'h2;
    #1 cmp("stall_on_start", 32'(stall_req), 32'd1);
    tick(); idle_inputs();
    run_busy("mult", MLAT, 1'b1);
    cmp("mult_hi", hi, 32'hFFFFFFFF);
    cmp("mult_lo", lo, 32'hFFFFFFFE);
    d_is_md = 1'b0;
    issue(4'd2, 32'hFFFFFFFF, 32'h2);
    run_busy("multu", MLAT, 1'b0);
    cmp("multu_hi", hi, 32'h00000001);
    cmp("multu_lo", lo, 32'hFFFFFFFE);

    // div / divu
    issue(4'd3, 32'hFFFFFFF9, 32'h2);
    run_busy("div", DLAT, 1'b0);
    cmp("div_lo", lo, 32'hFFFFFFFD);
    cmp("div_hi", hi, 32'hFFFFFFFF);
    issue(4'd4, 32'd7, 32'd2);
    run_busy("divu", DLAT, 1'b0);
    cmp("divu_lo", lo, 32'd3);
    cmp("divu_hi", hi, 32'd1);

    // mthi/mtlo and mfhi/mflo
    issue(4'd7, 32'h00001234, 32'd0);
    cmp("mthi_busy", 32'(busy), 32'd0);
    start = 1'b1; op = 4'd5;
    #1 cmp("mfhi_rdata", rdata, 32'h00001234);
    tick();
    issue(4'd8, 32'h0000CAFE, 32'd0);
    cmp("mtlo_busy", 32'(busy), 32'd0);
    start = 1'b1; op = 4'd6;
    #1 cmp("mflo_rdata", rdata, 32'h0000CAFE);
    tick(); idle_inputs();

    // divide by zero keeps HI/LO
    issue(4'd7, 32'h11, 32'd0);
    issue(4'd8, 32'h22, 32'd0);
    issue(4'd4, 32'd99, 32'd0);
    run_busy("divz", DLAT, 1'b0);
    cmp("divz_hi", hi, 32'h11);
    cmp("divz_lo", lo, 32'h22);

    // reset on the third busy cycle abandons the op
    issue(4'd3, 32'd100, 32'd7);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rst_mid_busy", 32'(busy), 32'd0);
    cmp("rst_mid_hi", hi, 32'd0);
    cmp("rst_mid_lo", lo, 32'd0);
    repeat (12) tick();
    cmp("rst_nocommit_hi", hi, 32'd0);
    cmp("rst_nocommit_lo", lo, 32'd0);

    // madd family
    issue(4'd8, 32'd1, 32'd0);
    issue(4'd9, 32'd2, 32'd3);
`ifdef MDU_MADD_EN
    run_busy("madd", MLAT, 1'b0);
    cmp("madd_hi", hi, 32'd0);
    cmp("madd_lo", lo, 32'd7);
`else
    cmp("madd_off_busy", 32'(busy), 32'd0);
    cmp("madd_off_lo", lo, 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      d_is_md = $urandom_range(0, 1);
      start   = ($urandom_range(0, 9) < 6);
      op      = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: rs_val = $urandom_range(0, 20);
        1: rs_val = 32'hFFFFFFFF - $urandom_range(0, 20);
        default: rs_val = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rt_val = 32'd0;
        1: rt_val = $urandom_range(1, 9);
        2: rt_val = 32'hFFFFFFFF - $urandom_range(0, 9);
        default: rt_val = $urandom;
      endcase
      if (rs_val == 32'h80000000 && rt_val == 32'hFFFFFFFF) rt_val = 32'd1;
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the 5-stage pipeline, sitting in the E stage beside the ALU.
- Owns the HI/LO registers and sequences multi-cycle mult/div operations with a latency counter.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Raises a stall request to the D-stage hazard logic while an operation is in flight.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (and madd family); must be >= 1
- DIV_LAT, 10, busy cycles for div/divu; must be >= 1
- CNT_W, 4, width of the latency counter; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  E-stage instruction is a valid MDU op this cycle
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu
- rs_val  in  32  forwarded rs operand (E stage)
- rt_val  in  32  forwarded rt operand (E stage)
- d_is_md  in  1  D-stage instruction is any MDU op (codes 1-12)
- busy  out  1  operation in flight
- stall_req  out  1  stall request to the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register
- rdata  out  32  mfhi/mflo result for the E-stage writeback mux

Behaviour:
- Reset: state IDLE, cnt=0, hi=0, lo=0, shadow regs=0. Outputs after reset: busy=0, stall_req=0, rdata=0.
- Reset mid-operation abandons the op; no commit.
- FSM states: IDLE, BUSY. busy = (state==BUSY).
- IDLE, start with a mul/div op (1-4, or 9-12 when enabled) at edge T:
  - Shadow HI/LO computed from rs_val/rt_val and latched at T.
  - cnt <= MULT_LAT or DIV_LAT; state <= BUSY.
- BUSY: each edge decrements cnt. At the edge where cnt==1: state <= IDLE, hi/lo <= shadow.
  - busy is high for exactly LAT cycles; new hi/lo become visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32 -> 64, hi = [63:32], lo = [31:0]. multu: unsigned.
  - div: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend. divu: unsigned.
  - Divide by zero: full DIV_LAT busy period runs, but shadow = current hi/lo, so HI/LO are unchanged.
- mthi/mtlo with start in IDLE: hi (or lo) <= rs_val at the next edge; no busy.
- mfhi/mflo: rdata combinational; op 5 -> hi, op 6 -> lo, anything else -> 0. Valid only in IDLE.
- Any start (any op) while BUSY: ignored. The hazard unit guarantees this does not occur.
- start with op 0, or an undefined code: no effect.
- stall_req = d_is_md && (busy || (start && op is a mul/div code)).
  - The instruction entering E with a mul/div start therefore stalls its D-stage MDU successor in the same cycle.

Optional Feature:
- Macro: MDU_MADD_EN
- Defined: op 9-12 accepted.
  - madd: {hi,lo} += signed rs*rt. maddu: unsigned.
  - msub: {hi,lo} -= signed rs*rt. msubu: unsigned.
  - All four use MULT_LAT. The accumulate base is the hi/lo value at the start edge.
  - d_is_md covers these codes.
- Not defined: op 9-12 behave as op 0 (no busy, no state change, no stall contribution).

Test Plan:
- mult rs=0xFFFFFFFF rt=0x00000002 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7) rt=0x00000002 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7 rt=2 -> lo=3 hi=1.
- hi=0x11, lo=0x22, then divu rt=0 -> busy 10 cycles, hi=0x11 lo=0x22 afterward.
- mult in flight with d_is_md=1 -> stall_req=1 every busy cycle, 0 the cycle busy falls; d_is_md=0 -> stall_req=0 throughout; start mult with d_is_md=1 same cycle -> stall_req=1.
- mthi rs=0x00001234 -> next cycle mfhi gives rdata=0x00001234; mtlo rs=0xCAFE then mflo -> rdata=0x0000CAFE, busy never asserted.
- reset asserted on 3rd busy cycle of div -> next cycle busy=0, hi=0, lo=0, no later commit. With MDU_MADD_EN: hi=0 lo=1, madd rs=2 rt=3 -> lo=7 after 5 cycles.
